// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execution datapath: data width, opcode and funct
// encodings, and the immediate-extension helpers.
package mips_pkg;

  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] word_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic word_t sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic word_t zext16(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/mips_datapath_if.sv
// Bundle between pipeline control (master) and the execution datapath (slave).
interface mips_datapath_if;
  import mips_pkg::*;

  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  word_t       rs_data;
  word_t       rt_data;
  logic [4:0]  rd_addr;
  word_t       rd_data;
  logic        rd_we;
  logic [5:0]  alu_opcode;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  word_t       alu_a;
  word_t       alu_b;
  logic [15:0] alu_imm;
  word_t       alu_result;
  word_t       mem_addr;
  word_t       mem_wdata;
  logic        mem_we;
  word_t       mem_rdata;

  modport master (
    output rs_addr, rt_addr, rd_addr, rd_data, rd_we,
           alu_opcode, alu_funct, alu_shamt, alu_a, alu_b, alu_imm,
           mem_addr, mem_wdata, mem_we,
    input  rs_data, rt_data, alu_result, mem_rdata
  );

  modport slave (
    input  rs_addr, rt_addr, rd_addr, rd_data, rd_we,
           alu_opcode, alu_funct, alu_shamt, alu_a, alu_b, alu_imm,
           mem_addr, mem_wdata, mem_we,
    output rs_data, rt_data, alu_result, mem_rdata
  );

endinterface

// File: rtl/mips_regfile.sv
// 2-read/1-write GPR file; $0 hardwired to zero.
// Optional GPR_WRITE_THROUGH_EN: a same-cycle write is bypassed onto the read ports.
module mips_regfile
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic [4:0] rd_addr,
  input  word_t      rd_data,
  input  logic       rd_we,
  output word_t      rs_data,
  output word_t      rt_data
);

  word_t regs [32];
  logic  wr_en;

  // rst is active-low: writes only land while out of reset
  assign wr_en = rst && rd_we && (rd_addr != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
`ifdef GPR_WRITE_THROUGH_EN
    if (wr_en && rd_addr == rs_addr) rs_data = rd_data;
    if (wr_en && rd_addr == rt_addr) rt_data = rd_data;
`endif
  end

endmodule

// File: rtl/mips_datapath.sv
// Execution datapath slice: register file, registered ALU, read-first word memory.
// Build option GPR_WRITE_THROUGH_EN enables register write-through (see mips_regfile).
module mips_datapath
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic            clk,
  input  logic            rst,
  mips_datapath_if.slave  dp
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  mips_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (dp.rs_addr),
    .rt_addr (dp.rt_addr),
    .rd_addr (dp.rd_addr),
    .rd_data (dp.rd_data),
    .rd_we   (dp.rd_we),
    .rs_data (dp.rs_data),
    .rt_data (dp.rt_data)
  );

  word_t      a, b, sx, zx, alu_nxt, alu_q;
  logic [4:0] shv;

  always_comb begin
    a       = dp.alu_a;
    b       = dp.alu_b;
    sx      = sext16(dp.alu_imm);
    zx      = zext16(dp.alu_imm);
    shv     = a[4:0];
    alu_nxt = '0;
    case (dp.alu_opcode)
      OP_R: begin
        case (dp.alu_funct)
          FN_SLL:          alu_nxt = b << dp.alu_shamt;
          FN_SRL:          alu_nxt = b >> dp.alu_shamt;
          FN_SRA:          alu_nxt = word_t'($signed(b) >>> dp.alu_shamt);
          FN_SLLV:         alu_nxt = b << shv;
          FN_SRLV:         alu_nxt = b >> shv;
          FN_SRAV:         alu_nxt = word_t'($signed(b) >>> shv);
          FN_ADD, FN_ADDU: alu_nxt = a + b;
          FN_SUB, FN_SUBU: alu_nxt = a - b;
          FN_AND:          alu_nxt = a & b;
          FN_OR:           alu_nxt = a | b;
          FN_XOR:          alu_nxt = a ^ b;
          FN_NOR:          alu_nxt = ~(a | b);
          FN_SLT:          alu_nxt = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          FN_SLTU:         alu_nxt = {{(DATA_W-1){1'b0}}, (a < b)};
          default:         alu_nxt = '0;
        endcase
      end
      // loads/stores produce the byte address for the memory stage
      OP_ADDI, OP_ADDIU,
      OP_LW, OP_SW:        alu_nxt = a + sx;
      OP_SLTI:             alu_nxt = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(sx))};
      OP_SLTIU:            alu_nxt = {{(DATA_W-1){1'b0}}, (a < sx)};
      OP_ANDI:             alu_nxt = a & zx;
      OP_ORI:              alu_nxt = a | zx;
      OP_XORI:             alu_nxt = a ^ zx;
      OP_LUI:              alu_nxt = {dp.alu_imm, 16'h0};
      default:             alu_nxt = '0;
    endcase
  end

  // Data memory: contents survive reset; high address bits alias.
  word_t          mem [MEM_WORDS];
  word_t          rdata_q;
  logic [AW-1:0]  midx;
  logic           unused_addr_hi;

  assign midx           = dp.mem_addr[AW-1:0];
  assign unused_addr_hi = ^dp.mem_addr[DATA_W-1:AW];

  always_ff @(posedge clk) begin
    if (rst && dp.mem_we) mem[midx] <= dp.mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      rdata_q <= '0;
    end else begin
      alu_q   <= alu_nxt;
      rdata_q <= mem[midx];
    end
  end

  assign dp.alu_result = alu_q;
  assign dp.mem_rdata  = rdata_q;

endmodule

// File: tb/tb_mips_datapath.sv
// Scoreboarded random bench for mips_datapath with a spec-level reference model.
`timescale 1ns/1ps
module tb_mips_datapath;

  localparam int MW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_datapath_if dp ();
  mips_datapath #(.MEM_WORDS(MW)) dut (.clk(clk), .rst(rst), .dp(dp));

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] wd;
    bit          we;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] a, b;
    logic [15:0] imm;
    logic [31:0] ma, mwd;
    bit          mwe;
  } stim_t;

  typedef struct { logic [31:0] rs, rt; } rd_exp_t;
  typedef struct { logic [31:0] alu, mem; bit mem_known; } rg_exp_t;

  rd_exp_t     q_rd[$];
  rg_exp_t     q_rg[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        issue = 1'b0;
  logic        issue_d = 1'b0;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [int];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU, straight from the instruction table.
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] sh, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] imm);
    logic [31:0] se, ze;
    int          s;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0, imm};
    if (op == 6'h00) begin
      s = (fn inside {6'h04, 6'h06, 6'h07}) ? int'(a[4:0]) : int'(sh);
      case (fn)
        6'h00, 6'h04: return b << s;
        6'h02, 6'h06: return b >> s;
        6'h03, 6'h07: return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24:        return a & b;
        6'h25:        return a | b;
        6'h26:        return a ^ b;
        6'h27:        return ~(a | b);
        6'h2A:        return (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, a < b};
        6'h2B:        return {31'h0, a < b};
        default:      return 32'h0;
      endcase
    end
    case (op)
      6'h08, 6'h09, 6'h23, 6'h2B: return a + se;
      6'h0A:  return (a[31] != se[31]) ? {31'h0, a[31]} : {31'h0, a < se};
      6'h0B:  return {31'h0, a < se};
      6'h0C:  return a & ze;
      6'h0D:  return a | ze;
      6'h0E:  return a ^ ze;
      6'h0F:  return {imm, 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] ad, input stim_t s);
    if (ad == 5'd0) return 32'h0;
`ifdef GPR_WRITE_THROUGH_EN
    if (s.we && s.rd == ad) return s.wd;
`endif
    return m_reg[ad];
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s = '{rs:0, rt:0, rd:0, wd:0, we:0, op:0, fn:0, sh:0, a:0, b:0, imm:0, ma:0, mwd:0, mwe:0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rd_exp_t e1;
    rg_exp_t e2;
    int      idx;
    @(posedge clk); #1;
    dp.rs_addr = s.rs;  dp.rt_addr = s.rt;
    dp.rd_addr = s.rd;  dp.rd_data = s.wd;  dp.rd_we = s.we;
    dp.alu_opcode = s.op; dp.alu_funct = s.fn; dp.alu_shamt = s.sh;
    dp.alu_a = s.a; dp.alu_b = s.b; dp.alu_imm = s.imm;
    dp.mem_addr = s.ma; dp.mem_wdata = s.mwd; dp.mem_we = s.mwe;
    issue = 1'b1;
    e1.rs = ref_rd(s.rs, s);
    e1.rt = ref_rd(s.rt, s);
    q_rd.push_back(e1);
    idx = int'(s.ma % MW);
    e2.alu       = ref_alu(s.op, s.fn, s.sh, s.a, s.b, s.imm);
    e2.mem_known = m_mem.exists(idx);
    e2.mem       = e2.mem_known ? m_mem[idx] : 32'h0;
    q_rg.push_back(e2);
    if (s.we && s.rd != 5'd0) m_reg[s.rd] = s.wd;
    if (s.mwe) m_mem[idx] = s.mwd;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    issue = 1'b0; dp.rd_we = 1'b0; dp.mem_we = 1'b0;
  endtask

  // Monitor: comb reads checked in the issue cycle, registered outputs one edge later.
  always @(posedge clk) issue_d <= issue;

  always @(negedge clk) begin
    rd_exp_t e1;
    rg_exp_t e2;
    if (issue) begin
      if (q_rd.size() == 0) check("rd_queue_underflow", 32'h1, 32'h0);
      else begin
        e1 = q_rd.pop_front();
        check("rs_data", dp.rs_data, e1.rs);
        check("rt_data", dp.rt_data, e1.rt);
      end
    end
    if (issue_d) begin
      if (q_rg.size() == 0) check("rg_queue_underflow", 32'h1, 32'h0);
      else begin
        e2 = q_rg.pop_front();
        check("alu_result", dp.alu_result, e2.alu);
        if (e2.mem_known) check("mem_rdata", dp.mem_rdata, e2.mem);
      end
    end
  end

  logic [5:0] ops [17] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                           6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
  logic [5:0] fns [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                           6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F,
                           6'h05, 6'h28};

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    stim_t s;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    dp.rs_addr = 0; dp.rt_addr = 0; dp.rd_addr = 0; dp.rd_data = 0; dp.rd_we = 0;
    dp.alu_opcode = 0; dp.alu_funct = 0; dp.alu_shamt = 0;
    dp.alu_a = 0; dp.alu_b = 0; dp.alu_imm = 0;
    dp.mem_addr = 0; dp.mem_wdata = 0; dp.mem_we = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_alu_result", dp.alu_result, 32'h0);
    check("reset_mem_rdata", dp.mem_rdata, 32'h0);
    @(negedge clk); rst = 1'b1;

    // Zero a memory window while sweeping every register for its reset value.
    for (int i = 0; i < 64; i++) begin
      s = blank();
      s.rs = 5'(i % 32); s.rt = 5'(31 - i % 32);
      s.ma = 32'(i); s.mwe = 1; s.mwd = 32'h0;
      drive(s);
    end

    // Register file directed cases
    s = blank(); s.rd = 5; s.wd = 32'h1234_5678; s.we = 1; drive(s);
    s = blank(); s.rs = 5; drive(s);
    s = blank(); s.rd = 0; s.wd = 32'hFFFF_FFFF; s.we = 1; drive(s);
    s = blank(); s.rs = 0; s.rt = 5; drive(s);
    s = blank(); s.rd = 3; s.wd = 32'h7; s.we = 1; s.rs = 3; drive(s);
    s = blank(); s.rs = 3; s.rt = 3; drive(s);

    // ALU directed cases
    s = blank(); s.fn = 6'h21; s.a = 32'hFFFF_FFFF; s.b = 32'h1; drive(s);
    s = blank(); s.fn = 6'h2A; s.a = 32'hFFFF_FFFF; s.b = 32'h1; drive(s);
    s = blank(); s.fn = 6'h2B; s.a = 32'hFFFF_FFFF; s.b = 32'h1; drive(s);
    s = blank(); s.fn = 6'h03; s.b = 32'h8000_0000; s.sh = 4; drive(s);
    s = blank(); s.op = 6'h0F; s.imm = 16'hABCD; drive(s);
    s = blank(); s.op = 6'h08; s.a = 32'h10; s.imm = 16'hFFFC; drive(s);
    s = blank(); s.op = 6'h0D; s.a = 32'h0; s.imm = 16'h8000; drive(s);

    // Memory directed cases: read-first, then aliasing
    s = blank(); s.ma = 9; s.mwe = 1; s.mwd = 32'hCAFE; drive(s);
    s = blank(); s.ma = 9; drive(s);
    s = blank(); s.ma = 32'(MW + 9); drive(s);

    // Asynchronous reset in the middle of activity
    idle();
    dp.alu_opcode = 6'h0F; dp.alu_imm = 16'hFFFF; dp.mem_addr = 32'd9; dp.rs_addr = 5'd5;
    @(posedge clk); #1;
    check("pre_rst_alu", dp.alu_result, 32'hFFFF_0000);
    check("pre_rst_mem", dp.mem_rdata, m_mem[9]);
    check("pre_rst_rs", dp.rs_data, m_reg[5]);
    #2 rst = 1'b0;
    #1;
    check("async_rst_alu", dp.alu_result, 32'h0);
    check("async_rst_mem", dp.mem_rdata, 32'h0);
    check("async_rst_rs", dp.rs_data, 32'h0);
    dp.rd_we = 1; dp.rd_addr = 5; dp.rd_data = 32'h1;
    dp.mem_we = 1; dp.mem_wdata = 32'hDEAD;
    @(posedge clk); #1;
    check("held_rst_alu", dp.alu_result, 32'h0);
    check("held_rst_rs", dp.rs_data, 32'h0);
    dp.rd_we = 0; dp.mem_we = 0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;

    s = blank(); s.ma = 9; s.rs = 5; drive(s);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      s = blank();
      s.rd  = 5'($urandom_range(0, 31));
      s.we  = $urandom_range(0, 1) == 1;
      s.wd  = rnd_word();
      s.rs  = ($urandom_range(0, 3) == 0) ? s.rd : 5'($urandom_range(0, 31));
      s.rt  = ($urandom_range(0, 3) == 0) ? s.rd : 5'($urandom_range(0, 31));
      s.op  = ops[$urandom_range(0, 16)];
      s.fn  = fns[$urandom_range(0, 19)];
      s.sh  = 5'($urandom_range(0, 31));
      s.a   = rnd_word();
      s.b   = rnd_word();
      s.imm = 16'($urandom);
      s.ma  = 32'($urandom_range(0, 63)) + 32'(MW) * 32'($urandom_range(0, 7));
      s.mwe = $urandom_range(0, 1) == 1;
      s.mwd = $urandom;
      drive(s);
    end

    idle();
    idle();
    check("rd_queue_drained", 32'(q_rd.size()), 32'h0);
    check("rg_queue_drained", 32'(q_rg.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
